// File: rtl/stepper_phase_decoder.sv
// Coil-phase bus monitor: reconstructs step position, direction, step period, skip/illegal faults and stall.
// Optional period measurement is enabled by defining PERIOD_MEAS_EN.
module stepper_phase_decoder #(
    parameter int unsigned FILT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned POS_W          = 32,
    parameter int unsigned PER_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ab_in,
    input  logic             clr,
    input  logic             fault_clr,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             moving,
    output logic             fault
);

    localparam int unsigned FC_W = $clog2(FILT_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_RUN, S_LOST} state_t;

    state_t           state, state_n;
    logic [3:0]       sync1, sync2, cand, acc, acc_d;
    logic [FC_W-1:0]  fcnt, fcnt_n;
    logic [TO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic [POS_W-1:0] position_n;
    logic             dir_n, step_n, fault_n, fault_set, is_step, ev;

    // Count consecutive equal synchronized samples; a restart counts as the first one.
    always_comb begin
        fcnt_n = fcnt;
        if (sync2 != cand)
            fcnt_n = FC_W'(1);
        else if (fcnt < FC_W'(FILT_CYCLES))
            fcnt_n = fcnt + FC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            fcnt  <= '0;
            acc   <= '0;
            acc_d <= '0;
        end else begin
            sync1 <= ab_in;
            sync2 <= sync1;
            cand  <= sync2;
            fcnt  <= fcnt_n;
            if (fcnt_n == FC_W'(FILT_CYCLES))
                acc <= sync2;
            acc_d <= acc;
        end
    end

    assign ev = (acc != acc_d);

    // Event classification against the previous accepted pattern (acc_d).
    always_comb begin
        state_n    = state;
        position_n = position;
        dir_n      = dir;
        step_n     = 1'b0;
        fault_set  = 1'b0;
        is_step    = 1'b0;
        if (ev) begin
            unique case (state)
                S_OFF: begin
                    if ($onehot(acc)) begin
                        state_n = S_ARMED;
                    end else if (acc != 4'b0000) begin
                        state_n   = S_LOST;
                        fault_set = 1'b1;
                    end
                end
                S_ARMED, S_RUN: begin
                    if (acc == {acc_d[2:0], acc_d[3]}) begin
                        is_step    = 1'b1;
                        dir_n      = 1'b1;
                        position_n = position + POS_W'(1);
                    end else if (acc == {acc_d[0], acc_d[3:1]}) begin
                        is_step    = 1'b1;
                        dir_n      = 1'b0;
                        position_n = position - POS_W'(1);
                    end else if (acc == {acc_d[1:0], acc_d[3:2]}) begin
                        state_n   = S_ARMED;
                        fault_set = 1'b1;
                    end else if (acc == 4'b0000) begin
                        state_n = S_OFF;
                    end else begin
                        state_n   = S_LOST;
                        fault_set = 1'b1;
                    end
                end
                S_LOST: begin
                    if ($onehot(acc))
                        state_n = S_ARMED;
                    else if (acc == 4'b0000)
                        state_n = S_OFF;
                end
                default: state_n = S_OFF;
            endcase
        end else if (state == S_RUN && tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = S_ARMED;
        end
        if (is_step) begin
            step_n  = 1'b1;
            state_n = S_RUN;
        end
        if (clr)
            position_n = '0;
        fault_n = (fault & ~fault_clr) | fault_set;
        if (is_step || state != S_RUN)
            tmo_cnt_n = '0;
        else
            tmo_cnt_n = tmo_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OFF;
            position   <= '0;
            dir        <= 1'b1;
            step_pulse <= 1'b0;
            moving     <= 1'b0;
            fault      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_n;
            position   <= position_n;
            dir        <= dir_n;
            step_pulse <= step_n;
            moving     <= (state_n == S_RUN);
            fault      <= fault_n;
            tmo_cnt    <= tmo_cnt_n;
        end
    end

`ifdef PERIOD_MEAS_EN
    logic [PER_W-1:0] per_cnt, per_cnt_n, period_n;
    logic             period_valid_n;

    // Only a step taken while already in RUN closes a valid period.
    always_comb begin
        period_n       = period;
        period_valid_n = period_valid;
        if (is_step && state == S_RUN) begin
            period_n       = per_cnt;
            period_valid_n = 1'b1;
        end
        if (state_n != S_RUN)
            period_valid_n = 1'b0;
        if (is_step)
            per_cnt_n = PER_W'(1);
        else if (&per_cnt)
            per_cnt_n = per_cnt;
        else
            per_cnt_n = per_cnt + PER_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            per_cnt      <= per_cnt_n;
            period       <= period_n;
            period_valid <= period_valid_n;
        end
    end
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder (FILT_CYCLES=4, TIMEOUT_CYCLES=1000) with a 4-bit-position twin for wrap.
module tb_stepper_phase_decoder;

`ifdef PERIOD_MEAS_EN
    localparam bit PM = 1'b1;
`else
    localparam bit PM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ab_in = 4'b0000;
    logic        clr = 1'b0;
    logic        fault_clr = 1'b0;
    logic [31:0] position, period, period4;
    logic [3:0]  position4;
    logic        dir, step_pulse, period_valid, moving, fault;
    logic        dir4, step_pulse4, period_valid4, moving4, fault4;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int lat;
    int pulses_snap;
    logic [3:0] cur;

    always #5 clk = ~clk;

    stepper_phase_decoder #(.FILT_CYCLES(4), .TIMEOUT_CYCLES(1000), .POS_W(32), .PER_W(32)) u_dut (
        .clk(clk), .rst(rst), .ab_in(ab_in), .clr(clr), .fault_clr(fault_clr),
        .position(position), .dir(dir), .step_pulse(step_pulse), .period(period),
        .period_valid(period_valid), .moving(moving), .fault(fault)
    );

    stepper_phase_decoder #(.FILT_CYCLES(4), .TIMEOUT_CYCLES(1000), .POS_W(4), .PER_W(32)) u_dut4 (
        .clk(clk), .rst(rst), .ab_in(ab_in), .clr(clr), .fault_clr(fault_clr),
        .position(position4), .dir(dir4), .step_pulse(step_pulse4), .period(period4),
        .period_valid(period_valid4), .moving(moving4), .fault(fault4)
    );

    always @(negedge clk) if (step_pulse) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        ab_in = p;
        repeat (n) @(negedge clk);
    endtask

    // Drive a pattern and count edges until step_pulse is seen (bounded).
    task automatic measure(input logic [3:0] p, output int l);
        ab_in = p;
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (step_pulse) begin
                l = i;
                break;
            end
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_position", position, 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_period", period, 32'd0);
        check("rst_pvalid", 32'(period_valid), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Forward run
        hold(4'b0001, 100);
        measure(4'b0010, lat);
        check("latency", 32'(lat), 32'd7);
        if (lat < 0) lat = 20;
        repeat (100 - lat) @(negedge clk);
        hold(4'b0100, 100);
        hold(4'b1000, 100);
        hold(4'b0001, 100);
        check("fwd_pulses", 32'(pulses), 32'd4);
        check("fwd_position", position, 32'd4);
        check("fwd_dir", 32'(dir), 32'd1);
        check("fwd_period", period, PM ? 32'd100 : 32'd0);
        check("fwd_pvalid", 32'(period_valid), 32'(PM));
        check("fwd_moving", 32'(moving), 32'd1);

        // Clear without a step, then reverse through zero
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_position", position, 32'd0);
        hold(4'b1000, 100);
        hold(4'b0100, 100);
        check("rev_position", position, 32'hFFFF_FFFE);
        check("rev_dir", 32'(dir), 32'd0);
        check("rev_position4", 32'(position4), 32'h0000_000E);

        // Forward to 7, then 8 more: 4-bit twin wraps through 0x8 to 0xF
        cur = 4'b0100;
        for (int k = 0; k < 9; k++) begin
            cur = rotl(cur);
            hold(cur, 100);
        end
        check("wrap_pre4", 32'(position4), 32'h0000_0007);
        check("wrap_pre32", position, 32'd7);
        cur = rotl(cur);
        hold(cur, 100);
        check("wrap_mid4", 32'(position4), 32'h0000_0008);
        for (int k = 0; k < 7; k++) begin
            cur = rotl(cur);
            hold(cur, 100);
        end
        check("wrap_end4", 32'(position4), 32'h0000_000F);
        check("wrap_end32", position, 32'd15);
        check("wrap_twin_flags", {26'd0, dir4, step_pulse4, period_valid4, moving4, fault4, 1'b0},
              {26'd0, 1'b1, 1'b0, PM, 1'b1, 1'b0, 1'b0});
        check("wrap_twin_period", period4, PM ? 32'd100 : 32'd0);

        // Glitch: 3-cycle neighbouring phase is filtered out (cur = 1000)
        pulses_snap = pulses;
        hold(4'b0001, 3);
        hold(4'b1000, 100);
        check("glitch_pulses", 32'(pulses), 32'(pulses_snap));
        check("glitch_position", position, 32'd15);

        // Skip 1000 -> 0010, then 0010 -> 0100 steps
        hold(4'b0010, 100);
        check("skip_fault", 32'(fault), 32'd1);
        check("skip_position", position, 32'd15);
        check("skip_moving", 32'(moving), 32'd0);
        check("skip_pvalid", 32'(period_valid), 32'd0);
        hold(4'b0100, 100);
        check("after_skip_pos", position, 32'd16);
        check("after_skip_moving", 32'(moving), 32'd1);

        // Illegal pattern and recovery
        hold(4'b0011, 100);
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_moving", 32'(moving), 32'd0);
        check("ill_position", position, 32'd16);
        pulses_snap = pulses;
        hold(4'b0010, 100);
        check("lost_arm_pulses", 32'(pulses), 32'(pulses_snap));
        check("lost_arm_moving", 32'(moving), 32'd0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("fault_clr", 32'(fault), 32'd0);
        // fault_clr high on the very edge the illegal pattern is classified
        ab_in = 4'b0101;
        repeat (6) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("fault_clr_vs_set", 32'(fault), 32'd1);
        repeat (50) @(negedge clk);
        hold(4'b0000, 100);
        hold(4'b0001, 100);
        hold(4'b0010, 100);
        check("rearm_step_pos", position, 32'd17);

        // Stall in RUN
        hold(4'b0100, 20);
        check("stall_pre_moving", 32'(moving), 32'd1);
        check("stall_pre_period", period, PM ? 32'd100 : 32'd0);
        check("stall_pre_pvalid", 32'(period_valid), 32'(PM));
        repeat (880) @(negedge clk);
        check("stall_mid_moving", 32'(moving), 32'd1);
        repeat (200) @(negedge clk);
        check("stall_moving", 32'(moving), 32'd0);
        check("stall_pvalid", 32'(period_valid), 32'd0);
        check("stall_position", position, 32'd18);
        hold(4'b0000, 100);
        check("off_moving", 32'(moving), 32'd0);
        pulses_snap = pulses;
        hold(4'b0001, 100);
        check("off_arm_pulses", 32'(pulses), 32'(pulses_snap));

        // clr on the step edge: count discarded, strobe kept
        ab_in = 4'b0010;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clrstep_position", position, 32'd0);
        check("clrstep_pulse", 32'(step_pulse), 32'd1);
        check("clrstep_dir", 32'(dir), 32'd1);
        repeat (93) @(negedge clk);
        hold(4'b0001, 100);
        check("back_position", position, 32'hFFFF_FFFF);
        check("back_dir", 32'(dir), 32'd0);

        // Asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        check("arst_position", position, 32'd0);
        check("arst_flags", {27'd0, dir, step_pulse, period_valid, moving, fault},
              {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("arst_period", period, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
